// File: rtl/sram_mport_ctrl.sv
// sram_mport_ctrl: single-clock controller for a 32-bit pipelined synchronous SRAM.
// It serves one CPU read/write port and NCH read-only DMA channels, with one SRAM
// access per clock.
//   iCLK/iRST              clock and synchronous active-high reset
//   iReq/iWe/iBe/iAddr/... CPU request; the grant oGnt is combinational in the
//                          request cycle
//   oRValid/oRData         CPU read response, RD_LAT cycles after the address strobe
//   iDReq/iDAddr           DMA read requests; oDGnt is the one-hot grant
//   oDRValid/oDRData       DMA read response; oDRValid is one-hot
//   SRAM_DQ, oSRAM_*       SRAM pins; the fixed chip-select and burst pins are tied off
module sram_mport_ctrl #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned AW         = 19,
  parameter logic [31:0] BASE       = 32'h1000_0000,
  parameter logic [31:0] LAST       = 32'h101F_FFFF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq,
  input  logic              iWe,
  input  logic [3:0]        iBe,
  input  logic [31:0]       iAddr,
  input  logic [31:0]       iWData,
  output logic              oGnt,
  output logic              oRValid,
  output logic [31:0]       oRData,
  input  logic [NCH-1:0]    iDReq,
  input  logic [32*NCH-1:0] iDAddr,
  output logic [NCH-1:0]    oDGnt,
  output logic [NCH-1:0]    oDRValid,
  output logic [31:0]       oDRData,
  inout  wire  [31:0]       SRAM_DQ,
  output logic [AW-1:0]     oSRAM_A,
  output logic [3:0]        oSRAM_BE_N,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_ADSP_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_CLK,
  output logic              oSRAM_CE1_N,
  output logic              oSRAM_CE2,
  output logic              oSRAM_CE3_N,
  output logic              oSRAM_ADSC_N,
  output logic              oSRAM_ADV_N,
  output logic              oSRAM_GW_N
);

  localparam int unsigned PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned LSTG = RD_LAT - 1;

  logic [NCH-1:0] dma_elig;
  logic           cpu_elig;
  logic           pipe_busy;
  logic           write_block;
  logic           dma_any;
  logic [PW-1:0]  dma_win;
  logic           cpu_gnt;
  logic [NCH-1:0] dma_gnt;
  logic [31:0]    sel_addr;
  logic [NCH-1:0] rsp_dv;
  int unsigned    best_d;
  int unsigned    cand_d;
  int unsigned    rr_base;

  logic [PW-1:0]  rr_ptr;
  logic [SW-1:0]  starve_cnt;
  logic           pipe_v   [RD_LAT];
  logic           pipe_cpu [RD_LAT];
  logic [PW-1:0]  pipe_ch  [RD_LAT];
  logic           dq_oe;
  logic [31:0]    dq_out;
  logic           unused_addr;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= LAST);
  endfunction

  // Fixed SRAM pins and clock forwarding
  assign oSRAM_CLK    = iCLK;
  assign oSRAM_CE1_N  = 1'b0;
  assign oSRAM_CE2    = 1'b1;
  assign oSRAM_CE3_N  = 1'b0;
  assign oSRAM_ADSC_N = 1'b1;
  assign oSRAM_ADV_N  = 1'b1;
  assign oSRAM_GW_N   = 1'b1;

  assign SRAM_DQ = dq_oe ? dq_out : 32'bz;
  assign oGnt    = cpu_gnt;
  assign oDGnt   = dma_gnt;
  // Byte offset and bits above the window never reach the SRAM address
  assign unused_addr = ^sel_addr;

  // Arbitration: CPU first unless the DMA side is starved; DMA side is round-robin
  always_comb begin
    cpu_elig    = iReq && in_win(iAddr);
    dma_elig    = '0;
    dma_any     = 1'b0;
    dma_win     = '0;
    cpu_gnt     = 1'b0;
    dma_gnt     = '0;
    sel_addr    = iAddr;
    best_d      = NCH;
    cand_d      = 0;
    rr_base     = 32'(rr_ptr);
    rsp_dv      = '0;
    // Output-valid stage counts as busy so the write never overlaps read data on DQ
    pipe_busy   = oRValid || (|oDRValid);
    for (int unsigned i = 0; i < RD_LAT; i++) pipe_busy = pipe_busy || pipe_v[i];
    write_block = cpu_elig && iWe && pipe_busy;

    for (int unsigned k = 0; k < NCH; k++) begin
      dma_elig[k] = iDReq[k] && in_win(iDAddr[32*k +: 32]);
      cand_d      = (k >= rr_base) ? (k - rr_base) : (k + NCH - rr_base);
      if (dma_elig[k] && (cand_d < best_d)) begin
        best_d  = cand_d;
        dma_win = PW'(k);
        dma_any = 1'b1;
      end
    end

    // A blocked write also holds DMA so the read pipeline drains
    if (!write_block) begin
      if (cpu_elig && !(dma_any && (starve_cnt == SW'(STARVE_MAX)))) begin
        cpu_gnt = 1'b1;
      end else if (dma_any) begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (dma_win == PW'(k)) begin
            dma_gnt[k] = 1'b1;
            sel_addr   = iDAddr[32*k +: 32];
          end
        end
      end
    end

    for (int unsigned k = 0; k < NCH; k++) begin
      rsp_dv[k] = pipe_v[LSTG] && !pipe_cpu[LSTG] && (pipe_ch[LSTG] == PW'(k));
    end
  end

  // Pin registers, read-tag pipeline, response capture, arbiter state
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSRAM_A      <= '0;
      oSRAM_BE_N   <= 4'hF;
      oSRAM_WE_N   <= 1'b1;
      oSRAM_ADSP_N <= 1'b1;
      oSRAM_OE_N   <= 1'b0;
      dq_oe        <= 1'b0;
      dq_out       <= '0;
      oRValid      <= 1'b0;
      oRData       <= '0;
      oDRValid     <= '0;
      oDRData      <= '0;
      rr_ptr       <= '0;
      starve_cnt   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_cpu[i] <= 1'b0;
        pipe_ch[i]  <= '0;
      end
    end else begin
      oSRAM_ADSP_N <= !(cpu_gnt || (|dma_gnt));
      if (cpu_gnt || (|dma_gnt)) oSRAM_A <= sel_addr[AW+1:2];
      oSRAM_WE_N   <= !(cpu_gnt && iWe);
      oSRAM_BE_N   <= (cpu_gnt && iWe) ? ~iBe : 4'h0;
      oSRAM_OE_N   <= cpu_gnt && iWe;
      dq_oe        <= cpu_gnt && iWe;
      dq_out       <= iWData;

      pipe_v[0]   <= (cpu_gnt && !iWe) || (|dma_gnt);
      pipe_cpu[0] <= cpu_gnt;
      pipe_ch[0]  <= dma_win;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_cpu[i] <= pipe_cpu[i-1];
        pipe_ch[i]  <= pipe_ch[i-1];
      end

      oRValid  <= pipe_v[LSTG] && pipe_cpu[LSTG];
      oRData   <= (pipe_v[LSTG] && pipe_cpu[LSTG]) ? SRAM_DQ : 32'h0;
      oDRValid <= rsp_dv;
      oDRData  <= (|rsp_dv) ? SRAM_DQ : 32'h0;

      if (|dma_gnt) rr_ptr <= (dma_win == PW'(NCH - 1)) ? '0 : PW'(dma_win + 1'b1);

      if ((|dma_gnt) || !(|dma_elig)) starve_cnt <= '0;
      else if (cpu_gnt && (starve_cnt != SW'(STARVE_MAX))) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
